// File: rtl/defuzz_centroid.sv
`timescale 1ns/1ps
// defuzz_centroid
// Sequential centroid defuzzifier. Accepts one (degree, singleton) pair per
// cycle, accumulates sum(mu) and sum(mu*s), then runs an 8-step restoring
// division to present y = sum(mu*s) / sum(mu) as a Q7.0 signed value.
//
// Ports:
//   clk        single clock, all state on rising edge
//   rst        synchronous active-high reset
//   in_valid   input beat valid
//   in_ready   block can accept a beat (only in the accumulate phase)
//   in_mu      rule strength, Q1.15 unsigned
//   in_s       rule singleton, Q7.0 signed
//   in_last    final beat of the frame
//   out_valid  result valid
//   out_ready  downstream accepts result
//   out_y      crisp result, Q7.0 signed
//   out_zero   frame had sum(mu) = 0, out_y forced to 0
module defuzz_centroid #(
  parameter int N_MAX = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] in_mu,
  input  logic [7:0]  in_s,
  input  logic        in_last,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [7:0]  out_y,
  output logic        out_zero
);

  localparam int LOG2 = $clog2(N_MAX);
  localparam int MW   = 16 + LOG2;
  localparam int WW   = 24 + LOG2;

  typedef enum logic [1:0] {ACC, DIV, OUT} state_t;

  state_t             state;
  state_t             state_next;

  logic [LOG2-1:0]    beat_cnt;
  logic [MW-1:0]      sum_mu;
  logic signed [WW-1:0] sum_w;
  logic signed [WW-1:0] prod;
  logic [3:0]         div_cnt;
  logic [WW-1:0]      rem;
  logic [7:0]         quot;

  logic               beat_fire;
  logic               frame_close;
  logic               div_done;
  logic               out_fire;

  logic [WW-1:0]      abs_w;
  logic [WW-1:0]      rem_cur;
  logic [WW-1:0]      rem_next;
  logic [WW-1:0]      dshift;
  logic [2:0]         bit_idx;
  logic               take;
  logic [7:0]         y_signed;

  assign beat_fire   = in_valid && in_ready;
  // The N_MAX-th beat closes the frame even without in_last, which is what
  // bounds the accumulator widths.
  assign frame_close = beat_fire && (in_last || (beat_cnt == LOG2'(N_MAX - 1)));
  assign div_done    = (state == DIV) && (div_cnt == 4'd8);
  assign out_fire    = out_valid && out_ready;

  // Unsigned degree times signed singleton, widened to the accumulator size
  // so the product sign-extends into sum_w.
  assign prod = WW'($signed({1'b0, in_mu})) * WW'($signed(in_s));

  // One restoring-division step. The dividend magnitude is taken straight
  // from sum_w on the first step so no separate load cycle is needed; the
  // divisor is pre-shifted to the weight of the quotient bit being decided.
  // The quotient never exceeds 128, so starting at bit 7 cannot overflow.
  always_comb begin
    abs_w    = sum_w[WW-1] ? WW'(-sum_w) : WW'(sum_w);
    rem_cur  = (div_cnt == 4'd0) ? abs_w : rem;
    bit_idx  = 3'd7 - div_cnt[2:0];
    dshift   = WW'(sum_mu) << bit_idx;
    take     = (rem_cur >= dshift);
    rem_next = take ? (rem_cur - dshift) : rem_cur;
    y_signed = sum_w[WW-1] ? 8'(-quot) : quot;
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ACC;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic: accumulate until the frame closes, divide for eight
  // cycles plus one load cycle, then hold the result until it is taken.
  always_comb begin
    state_next = state;
    case (state)
      ACC:     if (frame_close) state_next = DIV;
      DIV:     if (div_done)    state_next = OUT;
      OUT:     if (out_fire)    state_next = ACC;
      default: state_next = ACC;
    endcase
  end

  // Output decode. in_ready is masked by rst so nothing is taken on a reset
  // edge, and never looks at in_valid.
  always_comb begin
    in_ready  = (state == ACC) && !rst;
    out_valid = (state == OUT);
  end

  // Datapath: accumulators, divider and registered result.
  always_ff @(posedge clk) begin
    if (rst) begin
      beat_cnt <= '0;
      sum_mu   <= '0;
      sum_w    <= '0;
      div_cnt  <= '0;
      rem      <= '0;
      quot     <= '0;
      out_y    <= '0;
      out_zero <= 1'b0;
    end else begin
      case (state)
        ACC: begin
          if (beat_fire) begin
            sum_mu   <= sum_mu + MW'(in_mu);
            sum_w    <= sum_w + prod;
            beat_cnt <= beat_cnt + LOG2'(1);
          end
        end
        DIV: begin
          if (!div_done) begin
            rem     <= rem_next;
            quot    <= {quot[6:0], take};
            div_cnt <= div_cnt + 4'd1;
          end else begin
            // With an empty frame the quotient is meaningless; report zero.
            out_y    <= (sum_mu == '0) ? 8'd0 : y_signed;
            out_zero <= (sum_mu == '0);
          end
        end
        OUT: begin
          if (out_fire) begin
            beat_cnt <= '0;
            sum_mu   <= '0;
            sum_w    <= '0;
            div_cnt  <= '0;
            rem      <= '0;
            quot     <= '0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/defuzz_centroid.md
# defuzz_centroid

Sequential centroid (weighted-average) defuzzifier that turns a stream of rule strengths back into a crisp value. It consumes one (membership degree, singleton position) pair per cycle and accumulates Σμ and Σμ·s. At the end of a frame it performs a fixed-latency restoring division and presents y = Σμ·s / Σμ. It is the output end of the fuzzy datapath: the trapezoidal MFs map crisp Q7.0 inputs to Q1.15 degrees, and this block maps Q1.15 degrees back to Q7.0.

## Interface
- N_MAX, 16: maximum rules per frame (≥2, power of two); sets accumulator headroom.
- clk  in  1  single clock, all state on rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  input beat valid.
- in_ready  out  1  block can accept a beat.
- in_mu  in  16  rule strength, Q1.15 unsigned, full 0..65535 accepted.
- in_s  in  8  rule output singleton, Q7.0 signed.
- in_last  in  1  marks final beat of frame.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts result.
- out_y  out  8  crisp output, Q7.0 signed.
- out_zero  out  1  frame had Σμ = 0; out_y forced to 0.

## Operation
- States: ACC, DIV, OUT. Reset → ACC with accumulators, beat counter and divider cleared.
- Reset values:
  - out_valid = 0, out_y = 0, out_zero = 0.
  - in_ready = 0 while rst is high.
- ACC:
  - in_ready = 1.
  - Beat accepted when in_valid && in_ready.
  - On each beat: sum_mu += in_mu (unsigned, 16+log2(N_MAX) bits); sum_w += in_mu × in_s (signed 24-bit product, 24+log2(N_MAX)-bit accumulator). No overflow is possible by construction.
  - Beat counter increments per beat.
  - Frame closes on a beat with in_last = 1, or on the N_MAX-th beat regardless of in_last. Either way → DIV.
- DIV:
  - in_ready = 0.
  - Sign-magnitude restoring division of |sum_w| by sum_mu, exactly 8 iterations, one quotient bit per cycle, MSB first.
  - Quotient magnitude ≤ 128 by construction (weighted mean of values in [-128,127]).
  - Result is truncated toward zero, then sign-applied; −128 is representable.
  - If sum_mu = 0: division result is ignored, out_y = 0, out_zero = 1. Latency is unchanged.
  - After the 8th iteration → OUT.
- OUT:
  - out_valid = 1; out_y and out_zero held stable until out_ready.
  - Handshake at the edge where out_valid && out_ready: clear accumulators and counter, out_valid → 0 → ACC.
  - in_ready is 0 throughout OUT, so no overlap between frames.
- rst overrides any state in the same edge, including mid-frame and mid-division. The partial frame is discarded; no output is produced for it.
- in_valid while in_ready = 0 is ignored; upstream must hold the beat.

## Timing
- Accumulation: 1 beat per cycle sustained in ACC.
- Latency: the last beat is accepted at edge E. The DIV iterations occur at edges E+1..E+8. out_valid is high starting after edge E+9.
- out_valid is never asserted combinationally from inputs. out_y and out_zero are registered and change only on the E+9 load edge.
- Earliest next-frame beat: the edge after the output handshake edge. Minimum frame period = beats + 10 cycles with out_ready held at 1.
- in_ready depends only on state (registered), with no combinational path from in_valid.

## Test plan
- Single beat (μ=32767, s=50, last) → out_y=50, out_zero=0, out_valid rises 9 edges after acceptance.
- Two beats (μ=32767, s=−100), (μ=16384, s=20, last) → Σμs=−2949020, Σμ=49151, out_y=−59 (truncation toward zero).
- Three beats all μ=0, arbitrary s → out_y=0, out_zero=1, same 9-cycle latency.
- Backpressure: hold out_ready=0 for 5 cycles after out_valid → out_y/out_zero stable, in_ready=0, in_valid beats ignored. Release → handshake, in_ready=1 next cycle, next frame (μ=100, s=−7, last) → out_y=−7.
- N_MAX=4: four beats μ=65535, s=−128 with in_last=0 → frame auto-closes after beat 4, out_y=−128; a fifth offered beat waits (in_ready=0).
- Assert rst during DIV iteration 4 → next cycle state ACC, out_valid=0, out_y=0, in_ready=1. A new frame (μ=1000, s=3, last) → out_y=3 with no contamination from the aborted frame.
